// File: rtl/guess_search.sv
//==============================================================================
// Module      : guess_search
// Description : Sequential binary-search controller driving the b operand of a
//               3-bit magnitude comparator. Converges on the secret operand in
//               at most four probes and reports done/fail with the found value.
//               Optional macro GUESS_STEPS_EN adds the 3-bit probe counter
//               output 'steps'.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module guess_search (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       L,
  input  logic       E,
  input  logic       G,
  output logic       b2,
  output logic       b1,
  output logic       b0,
  output logic       busy,
  output logic       done,
  output logic       fail,
`ifdef GUESS_STEPS_EN
  output logic [2:0] steps,
`endif
  output logic [2:0] res
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_EVAL  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  localparam logic [2:0] c_LO_INIT = 3'd0;
  localparam logic [2:0] c_HI_INIT = 3'd7;
  localparam logic [2:0] c_G_INIT  = 3'd3;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_lo, r_hi, r_g, r_res;
  logic [2:0] w_lo_nxt, w_hi_nxt, w_g_nxt, w_res_nxt;
  logic       r_busy, r_done, r_fail;
  logic       w_busy_nxt, w_done_nxt, w_fail_nxt;
  logic [3:0] w_sum_up, w_sum_dn;
`ifdef GUESS_STEPS_EN
  logic [2:0] r_steps, w_steps_nxt;
`endif

  // Midpoint sums are 4 bits wide so g+1+hi cannot overflow; the bound
  // checks in EVAL guarantee g<hi before +1 and g>lo before -1.
  assign w_sum_up = {1'b0, r_g} + 4'd1 + {1'b0, r_hi};
  assign w_sum_dn = {1'b0, r_lo} + {1'b0, r_g} - 4'd1;

  // Next-state, search-window and result logic.
  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_g_nxt     = r_g;
    w_res_nxt   = r_res;
`ifdef GUESS_STEPS_EN
    w_steps_nxt = r_steps;
`endif
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          w_lo_nxt    = c_LO_INIT;
          w_hi_nxt    = c_HI_INIT;
          w_g_nxt     = c_G_INIT;
          w_res_nxt   = 3'd0;
`ifdef GUESS_STEPS_EN
          w_steps_nxt = 3'd0;
`endif
          w_state_nxt = ST_PROBE;
        end
      end
      ST_PROBE: begin
        // Settle cycle for the external comparator.
        w_state_nxt = ST_EVAL;
`ifdef GUESS_STEPS_EN
        w_steps_nxt = r_steps + 3'd1;
`endif
      end
      ST_EVAL: begin
        case ({L, E, G})
          3'b010: begin
            w_res_nxt   = r_g;
            w_state_nxt = ST_DONE;
          end
          3'b001: begin
            if (r_g == r_hi) begin
              w_state_nxt = ST_FAIL;
            end else begin
              w_lo_nxt    = r_g + 3'd1;
              w_g_nxt     = 3'(w_sum_up >> 1);
              w_state_nxt = ST_PROBE;
            end
          end
          3'b100: begin
            if (r_g == r_lo) begin
              w_state_nxt = ST_FAIL;
            end else begin
              w_hi_nxt    = r_g - 3'd1;
              w_g_nxt     = 3'(w_sum_dn >> 1);
              w_state_nxt = ST_PROBE;
            end
          end
          default: w_state_nxt = ST_FAIL;
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Status flags are decoded from the next state so they leave a flop.
    w_busy_nxt = (w_state_nxt == ST_PROBE) || (w_state_nxt == ST_EVAL);
    w_done_nxt = (w_state_nxt == ST_DONE);
    w_fail_nxt = (w_state_nxt == ST_FAIL);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lo    <= c_LO_INIT;
      r_hi    <= c_HI_INIT;
      r_g     <= 3'd0;
      r_res   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
`ifdef GUESS_STEPS_EN
      r_steps <= 3'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_g     <= w_g_nxt;
      r_res   <= w_res_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_fail  <= w_fail_nxt;
`ifdef GUESS_STEPS_EN
      r_steps <= w_steps_nxt;
`endif
    end
  end

  assign {b2, b1, b0} = r_g;
  assign busy         = r_busy;
  assign done         = r_done;
  assign fail         = r_fail;
  assign res          = r_res;
`ifdef GUESS_STEPS_EN
  assign steps        = r_steps;
`endif

endmodule

`default_nettype wire
